// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic [0:0] {ARB, GRANT} state_t;

   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nreq);
      return (ptr + 1 >= nreq) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after i_ptr, wrapping.
module rr_pick #(
   parameter int unsigned NREQ = 4,
   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [IW-1:0]   o_idx,
   output logic            o_any
);

   logic [2*NREQ-1:0] dbl;
   logic [2*NREQ-1:0] masked;
   logic              found;

   // Upper copy of the request vector supplies the wrapped-around candidates.
   always_comb begin
      dbl    = {i_req, i_req};
      masked = '0;
      found  = 1'b0;
      o_idx  = '0;
      o_gnt  = '0;
      for (int i = 0; i < 2 * NREQ; i++) begin
         masked[i] = dbl[i] && (i >= int'(i_ptr));
      end
      for (int i = 0; i < 2 * NREQ; i++) begin
         if (!found && masked[i]) begin
            found = 1'b1;
            o_idx = IW'(i % NREQ);
         end
      end
      if (found) o_gnt[o_idx] = 1'b1;
   end

   assign o_any = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port; grants are locked per burst
// until last is accepted or MAXBURST beats have transferred.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned DSIZE    = 32,
   parameter int unsigned MAXBURST = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [NREQ-1:0]       i_valid,
   input  logic [NREQ*DSIZE-1:0] i_data,
   input  logic [NREQ-1:0]       i_last,
   output logic [NREQ-1:0]       o_ready,
   input  logic                  i_wfull,
   output logic                  o_wr,
   output logic [DSIZE-1:0]      o_wdata,
   output logic [NREQ-1:0]       o_gnt,
   output logic                  o_busy
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = $clog2(MAXBURST + 1);

   state_t          state_q;
   logic [IW-1:0]   g_q;
   logic [IW-1:0]   rr_ptr_q;
   logic [CW-1:0]   beat_cnt_q;
   logic [NREQ-1:0] gnt_q;
   logic            busy_q;

   logic [NREQ-1:0] pick_gnt;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;
   logic            accept;
   logic            burst_done;

   rr_pick #(
      .NREQ (NREQ)
   ) u_rr_pick (
      .i_req (i_valid),
      .i_ptr (rr_ptr_q),
      .o_gnt (pick_gnt),
      .o_idx (pick_idx),
      .o_any (pick_any)
   );

   // gnt_q is zero outside GRANT, so ready needs no extra state qualification.
   assign accept     = busy_q && i_valid[g_q] && !i_wfull;
   assign burst_done = accept && (i_last[g_q] || (beat_cnt_q + 1'b1 == CW'(MAXBURST)));
   assign o_ready    = gnt_q & {NREQ{!i_wfull}};
   assign o_wr       = accept;
   assign o_gnt      = gnt_q;
   assign o_busy     = busy_q;

   always_comb begin
      o_wdata = '0;
      if (busy_q) o_wdata = i_data[DSIZE*32'(g_q) +: DSIZE];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ARB;
         g_q        <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         gnt_q      <= '0;
         busy_q     <= 1'b0;
      end else begin
         unique case (state_q)
            ARB: begin
               if (pick_any) begin
                  state_q    <= GRANT;
                  g_q        <= pick_idx;
                  gnt_q      <= pick_gnt;
                  busy_q     <= 1'b1;
                  beat_cnt_q <= '0;
               end
            end
            GRANT: begin
               if (accept) begin
                  beat_cnt_q <= beat_cnt_q + 1'b1;
                  if (burst_done) begin
                     state_q  <= ARB;
                     gnt_q    <= '0;
                     busy_q   <= 1'b0;
                     rr_ptr_q <= IW'(rr_next(32'(g_q), NREQ));
                  end
               end
            end
            default: state_q <= ARB;
         endcase
      end
   end

endmodule
